character_motion_controller: RTL and testbench



---
 rtl/character_motion_controller.sv | 194 +++++++++++++++++++
 tb/tb_character_motion_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/character_motion_controller.sv
// character_motion_controller
//   Turns debounced buttons and collision flags into the character movement
//   state and signed velocities used by the display controller and the
//   position integrator. All registers advance only on sys_clk edges where
//   the character_clk pulse is high.
//
// Ports
//   sys_clk        system clock
//   sys_rst        synchronous active-high reset (wins over character_clk)
//   character_clk  one-sys_clk-wide update pulse
//   btn_left/right/jump  debounced buttons
//   pause          freeze request
//   on_ground      feet touching floor
//   hit_wall       side collision this tick
//   hit_ceiling    head collision this tick
//   char_state     movement state (encoding in table below)
//   vel_x, vel_y   signed velocities, + = right / up
//   charge_level   current charge count
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// IDLE (0)       | standing still on the ground
// LEFT (1)       | walking left at -WALK_VEL
// RIGHT (2)      | walking right at +WALK_VEL
// CHARGE (3)     | jump button held, charge_level counting up
// JUMP (4)       | airborne, gravity applied every tick
// COLLISION (5)  | one-tick wall bounce, vel_x already mirrored
// FALL_TO_GROUND (6) | one-tick landing, vel_y holds impact speed
// HOLD (7)       | paused, previous state kept in saved_state
module character_motion_controller #(
  parameter int SIGNED_PHY_WIDTH = 17,
  parameter int CHARGE_WIDTH     = 6,
  parameter int MAX_VEL_Y        = 10,
  parameter int WALK_VEL         = 2,
  parameter int AIR_VEL_X        = 3,
  parameter int GRAVITY          = 1
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               character_clk,
  input  logic                               btn_left,
  input  logic                               btn_right,
  input  logic                               btn_jump,
  input  logic                               pause,
  input  logic                               on_ground,
  input  logic                               hit_wall,
  input  logic                               hit_ceiling,
  output logic [2:0]                         char_state,
  output logic signed [SIGNED_PHY_WIDTH-1:0] vel_x,
  output logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
  output logic [CHARGE_WIDTH-1:0]            charge_level
);

  localparam int W  = SIGNED_PHY_WIDTH;
  localparam int CW = CHARGE_WIDTH;
  localparam int PW = SIGNED_PHY_WIDTH + CHARGE_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_LEFT           = 3'd1,
    S_RIGHT          = 3'd2,
    S_CHARGE         = 3'd3,
    S_JUMP           = 3'd4,
    S_COLLISION      = 3'd5,
    S_FALL_TO_GROUND = 3'd6,
    S_HOLD           = 3'd7
  } state_t;

  localparam logic signed [W-1:0] ZERO     = '0;
  localparam logic signed [W-1:0] WALK     = W'(WALK_VEL);
  localparam logic signed [W-1:0] AIR_X    = W'(AIR_VEL_X);
  localparam logic signed [W-1:0] GRAV     = W'(GRAVITY);
  localparam logic signed [W-1:0] NEG_MAX  = -(W'(MAX_VEL_Y));
  localparam logic [CW-1:0]       CHG_LAST = '1;

  state_t state;
  state_t saved_state;

  logic                 left_only;
  logic                 right_only;
  logic                 landing;
  logic [PW-1:0]        launch_prod;
  logic [PW-1:0]        launch_shift;
  logic signed [W-1:0]  launch_vy;
  logic signed [W-1:0]  launch_vx;
  logic signed [W-1:0]  vy_fall;

  assign char_state = state;

  always_comb begin
    left_only  = btn_left & ~btn_right;
    right_only = btn_right & ~btn_left;
    landing    = on_ground && (vel_y <= ZERO);

    // (charge_level+1) fits easily in PW bits, so the product cannot overflow.
    launch_prod  = (PW'(charge_level) + PW'(1)) * PW'(MAX_VEL_Y);
    launch_shift = launch_prod >> CW;
    launch_vy    = (launch_shift == '0) ? W'(1) : launch_shift[W-1:0];

    launch_vx = ZERO;
    if (left_only)       launch_vx = -AIR_X;
    else if (right_only) launch_vx = AIR_X;

    // Compare before subtracting so the clamp never depends on wraparound.
    if (vel_y < NEG_MAX + GRAV) vy_fall = NEG_MAX;
    else                        vy_fall = vel_y - GRAV;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      saved_state  <= S_IDLE;
      vel_x        <= ZERO;
      vel_y        <= ZERO;
      charge_level <= '0;
    end else if (character_clk) begin
      if (pause && state != S_HOLD) begin
        saved_state <= state;
        state       <= S_HOLD;
      end else begin
        case (state)
          S_HOLD: begin
            if (!pause) state <= saved_state;
          end

          S_IDLE, S_LEFT, S_RIGHT: begin
            vel_y <= ZERO;
            if (!on_ground) begin
              // walk-off: keep horizontal momentum, start falling from rest
              state <= S_JUMP;
            end else if (btn_jump) begin
              state        <= S_CHARGE;
              vel_x        <= ZERO;
              charge_level <= '0;
            end else if (left_only) begin
              state <= S_LEFT;
              vel_x <= -WALK;
            end else if (right_only) begin
              state <= S_RIGHT;
              vel_x <= WALK;
            end else begin
              state <= S_IDLE;
              vel_x <= ZERO;
            end
          end

          S_CHARGE: begin
            vel_x <= ZERO;
            vel_y <= ZERO;
            if (!btn_jump || charge_level == CHG_LAST) begin
              state        <= S_JUMP;
              vel_y        <= launch_vy;
              vel_x        <= launch_vx;
              charge_level <= '0;
            end else begin
              charge_level <= charge_level + CW'(1);
            end
          end

          S_JUMP: begin
            if (landing) begin
              state <= S_FALL_TO_GROUND;
              vel_x <= ZERO;
            end else begin
              if (hit_wall) begin
                state <= S_COLLISION;
                vel_x <= -vel_x;
              end
              if (hit_ceiling && vel_y > ZERO) vel_y <= ZERO;
              else                             vel_y <= vy_fall;
            end
          end

          S_COLLISION: begin
            if (landing) begin
              state <= S_FALL_TO_GROUND;
              vel_x <= ZERO;
            end else begin
              state <= S_JUMP;
              vel_y <= vy_fall;
            end
          end

          S_FALL_TO_GROUND: begin
            state <= S_IDLE;
            vel_x <= ZERO;
            vel_y <= ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_character_motion_controller.sv
// Directed bench for character_motion_controller. Each tick() raises
// character_clk for exactly one sys_clk edge; outputs are checked on the
// following falling edge against hand-computed values.
module tb_character_motion_controller;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               character_clk = 1'b0;
  logic               btn_left = 1'b0;
  logic               btn_right = 1'b0;
  logic               btn_jump = 1'b0;
  logic               pause = 1'b0;
  logic               on_ground = 1'b1;
  logic               hit_wall = 1'b0;
  logic               hit_ceiling = 1'b0;
  logic [2:0]         char_state;
  logic signed [16:0] vel_x;
  logic signed [16:0] vel_y;
  logic [5:0]         charge_level;

  int n_checks = 0;
  int n_fail   = 0;

  character_motion_controller dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .character_clk(character_clk),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_jump     (btn_jump),
    .pause        (pause),
    .on_ground    (on_ground),
    .hit_wall     (hit_wall),
    .hit_ceiling  (hit_ceiling),
    .char_state   (char_state),
    .vel_x        (vel_x),
    .vel_y        (vel_y),
    .charge_level (charge_level)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int st, input int vx, input int vy);
    check({tag, ".state"}, int'(char_state), st);
    check({tag, ".vel_x"}, int'(vel_x), vx);
    check({tag, ".vel_y"}, int'(vel_y), vy);
  endtask

  task automatic tick();
    @(negedge sys_clk) character_clk = 1'b1;
    @(negedge sys_clk) character_clk = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk) sys_rst = 1'b1;
    @(negedge sys_clk) sys_rst = 1'b0;
  endtask

  // Charge from IDLE for n ticks (n-1 final charge level) with jump held.
  task automatic charge(input int n);
    btn_jump = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    check_out("reset", 0, 0, 0);
    check("reset.charge", int'(charge_level), 0);

    // full charge with right held: auto-launch after charge_level 63
    btn_right = 1'b1;
    btn_jump  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      check($sformatf("charge_full.state%0d", i), int'(char_state), 3);
      check($sformatf("charge_full.level%0d", i), int'(charge_level), i);
    end
    tick();
    check_out("auto_launch", 4, 3, 10);
    check("auto_launch.charge", int'(charge_level), 0);

    // free fall: 9 down to -10, then saturates
    btn_right = 1'b0;
    btn_jump  = 1'b0;
    on_ground = 1'b0;
    for (int v = 9; v >= -10; v--) begin
      tick();
      check($sformatf("fall.vy%0d", v), int'(vel_y), v);
    end
    tick();
    tick();
    check_out("fall_sat", 4, 3, -10);
    on_ground = 1'b1;
    tick();
    check_out("land_fall", 6, 0, -10);
    tick();
    check_out("land_idle", 0, 0, 0);

    // one-tick press: launch speed clamps to 1, then land from vel_y 0
    btn_jump = 1'b1;
    tick();
    check_out("tap_charge", 3, 0, 0);
    btn_jump = 1'b0;
    tick();
    check_out("tap_launch", 4, 0, 1);
    tick();
    check_out("tap_grav", 4, 0, 0);
    tick();
    check_out("tap_land", 6, 0, 0);
    tick();
    check_out("tap_idle", 0, 0, 0);

    // 32-tick charge, launch right; ceiling, wall, landing priority
    charge(32);
    check("half.level", int'(charge_level), 31);
    btn_jump  = 1'b0;
    btn_right = 1'b1;
    tick();
    check_out("half_launch", 4, 3, 5);
    btn_right = 1'b0;
    on_ground = 1'b0;
    tick();
    check_out("half_g1", 4, 3, 4);
    hit_ceiling = 1'b1;
    tick();
    check_out("ceiling", 4, 3, 0);
    hit_ceiling = 1'b0;
    tick();
    check_out("after_ceiling", 4, 3, -1);
    hit_wall = 1'b1;
    tick();
    check_out("wall", 5, -3, -2);
    hit_wall = 1'b0;
    tick();
    check_out("after_wall", 4, -3, -3);
    hit_wall  = 1'b1;
    on_ground = 1'b1;
    tick();
    check_out("wall_land", 6, 0, -3);
    hit_wall = 1'b0;
    tick();
    check_out("wall_land_idle", 0, 0, 0);

    // pause mid-jump at vel_y 3
    charge(32);
    btn_jump = 1'b0;
    tick();
    check_out("p_launch", 4, 0, 5);
    on_ground = 1'b0;
    tick();
    tick();
    check_out("p_pre", 4, 0, 3);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("hold%0d", i), 7, 0, 3);
    end
    pause = 1'b0;
    tick();
    check_out("unpause", 4, 0, 3);
    tick();
    check_out("unpause_g", 4, 0, 2);
    repeat (100) @(negedge sys_clk);
    check_out("no_tick", 4, 0, 2);

    // reset mid-jump at vel_y 7, character_clk low
    do_reset();
    on_ground = 1'b1;
    charge(45);
    btn_jump = 1'b0;
    tick();
    check_out("j7_launch", 4, 0, 7);
    on_ground = 1'b0;
    do_reset();
    check_out("reset_mid", 0, 0, 0);
    check("reset_mid.charge", int'(charge_level), 0);

    // reset mid-charge with character_clk high on the reset edge
    on_ground = 1'b1;
    charge(5);
    check("rc.level", int'(charge_level), 4);
    @(negedge sys_clk) begin sys_rst = 1'b1; character_clk = 1'b1; end
    @(negedge sys_clk) begin sys_rst = 1'b0; character_clk = 1'b0; end
    check_out("reset_charge", 0, 0, 0);
    check("reset_charge.level", int'(charge_level), 0);
    btn_jump = 1'b0;

    // walking and walk-off
    btn_left = 1'b1;
    tick();
    check_out("walk_left", 1, -2, 0);
    btn_right = 1'b1;
    tick();
    check_out("walk_both", 0, 0, 0);
    btn_left = 1'b0;
    tick();
    check_out("walk_right", 2, 2, 0);
    btn_right = 1'b0;
    tick();
    check_out("walk_release", 0, 0, 0);
    on_ground = 1'b0;
    tick();
    check_out("walk_off", 4, 0, 0);
    on_ground = 1'b1;
    tick();
    check_out("walk_off_land", 6, 0, 0);
    tick();
    check_out("walk_off_idle", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
